fc_l2_port_arbiter: RTL and testbench

- Shares one L2 TCDM-protocol master port (req/gnt request channel, r_valid response channel) among N_REQ requesters inside the FC subsystem.
- Typical use: FC core data port plus debug or HWPE-config traffic.
- Round-robin arbitration on the request channel.
- An in-order ID FIFO routes each response back to the requester that issued the matching request.
- Limits outstanding transactions to MAX_OUTSTANDING.

---
 rtl/fc_l2_port_arbiter.sv | 132 +++++++++++++
 tb/tb_fc_l2_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_l2_port_arbiter.sv
// rtl/fc_l2_port_arbiter.sv - round-robin arbiter sharing one L2 TCDM master port
// Responses are steered back to their issuer through an in-order ID FIFO.
module fc_l2_port_arbiter #(
   parameter int N_REQ           = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [N_REQ-1:0]                req_i,
   input  logic [N_REQ*ADDR_WIDTH-1:0]     add_i,
   input  logic [N_REQ-1:0]                wen_i,
   input  logic [N_REQ*DATA_WIDTH-1:0]     wdata_i,
   input  logic [N_REQ*(DATA_WIDTH/8)-1:0] be_i,
   output logic [N_REQ-1:0]                gnt_o,
   output logic [N_REQ-1:0]                r_valid_o,
   output logic [DATA_WIDTH-1:0]           r_rdata_o,
   output logic                            r_opc_o,
   output logic                            m_req_o,
   output logic [ADDR_WIDTH-1:0]           m_add_o,
   output logic                            m_wen_o,
   output logic [DATA_WIDTH-1:0]           m_wdata_o,
   output logic [DATA_WIDTH/8-1:0]         m_be_o,
   input  logic                            m_gnt_i,
   input  logic                            m_r_valid_i,
   input  logic [DATA_WIDTH-1:0]           m_r_rdata_i,
   input  logic                            m_r_opc_i,
   output logic                            busy_o,
   output logic                            err_unexp_rsp_o
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int FP_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [FP_W-1:0]  FP_LAST  = FP_W'(MAX_OUTSTANDING - 1);
   localparam logic [PTR_W-1:0] SEL_LAST = PTR_W'(N_REQ - 1);

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] sel;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] fifo_q [MAX_OUTSTANDING];
   logic [FP_W-1:0]  wr_ptr;
   logic [FP_W-1:0]  rd_ptr;
   logic [CNT_W-1:0] count;
   logic             err_q;
   logic             found;
   logic             can_issue;
   logic             push;
   logic             pop;
   logic             unexp;
   int               idx;

   // First requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % N_REQ;
         if (!found && req_i[idx]) begin
            sel   = PTR_W'(idx);
            found = 1'b1;
         end
      end
   end

   assign head      = fifo_q[rd_ptr];
   assign pop       = m_r_valid_i && (count != '0);
   assign unexp     = m_r_valid_i && (count == '0);
   // A retiring response frees a slot in the same cycle, so a full FIFO can still issue.
   assign can_issue = (count < MAX_CNT) || pop;
   assign m_req_o   = (|req_i) && can_issue;
   assign push      = m_req_o && m_gnt_i;

   assign m_add_o   = m_req_o ? add_i[sel*ADDR_WIDTH +: ADDR_WIDTH]   : '0;
   assign m_wdata_o = m_req_o ? wdata_i[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign m_be_o    = m_req_o ? be_i[sel*BE_W +: BE_W]                : '0;
   assign m_wen_o   = m_req_o ? wen_i[sel]                            : 1'b1;

   assign r_rdata_o = m_r_valid_i ? m_r_rdata_i : '0;
   assign r_opc_o   = m_r_valid_i ? m_r_opc_i   : 1'b0;

   always_comb begin
      gnt_o     = '0;
      r_valid_o = '0;
      if (push) begin
         gnt_o[sel] = 1'b1;
      end
      if (pop) begin
         r_valid_o[head] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr] <= sel;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == FP_LAST) ? '0 : wr_ptr + 1'b1;
            rr_ptr <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == FP_LAST) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
         if (unexp) begin
            err_q <= 1'b1;
         end
      end
   end

   assign busy_o          = (count != '0);
   assign err_unexp_rsp_o = err_q;

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// tb/tb_fc_l2_port_arbiter.sv - self-checking bench for fc_l2_port_arbiter
// Directed scenarios followed by randomized traffic against a queue-based model.
module tb_fc_l2_port_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req;
   logic [N*AW-1:0]   add;
   logic [N-1:0]      wen;
   logic [N*DW-1:0]   wdata;
   logic [N*BW-1:0]   be;
   logic [N-1:0]      gnt;
   logic [N-1:0]      rvalid;
   logic [DW-1:0]     rdata;
   logic              opc;
   logic              mreq;
   logic [AW-1:0]     madd;
   logic              mwen;
   logic [DW-1:0]     mwdata;
   logic [BW-1:0]     mbe;
   logic              mgnt;
   logic              mrv;
   logic [DW-1:0]     mrdata;
   logic              mropc;
   logic              busy;
   logic              err;

   int tests = 0;
   int fails = 0;

   fc_l2_port_arbiter #(
      .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
      .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(rvalid),
      .r_rdata_o(rdata), .r_opc_o(opc), .m_req_o(mreq), .m_add_o(madd),
      .m_wen_o(mwen), .m_wdata_o(mwdata), .m_be_o(mbe), .m_gnt_i(mgnt),
      .m_r_valid_i(mrv), .m_r_rdata_i(mrdata), .m_r_opc_i(mropc),
      .busy_o(busy), .err_unexp_rsp_o(err)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req    = '0;
      add    = '0;
      wen    = '1;
      wdata  = '0;
      be     = '0;
      mgnt   = 1'b0;
      mrv    = 1'b0;
      mrdata = '0;
      mropc  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      tests++; if (gnt !== 2'b00)   begin fails++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      tests++; if (rvalid !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
      tests++; if (mreq !== 1'b0)   begin fails++; $display("FAIL reset_mreq: got %b expected 0", mreq); end
      tests++; if (madd !== '0)     begin fails++; $display("FAIL reset_madd: got %h expected 0", madd); end
      tests++; if (mwdata !== '0)   begin fails++; $display("FAIL reset_mwdata: got %h expected 0", mwdata); end
      tests++; if (mbe !== '0)      begin fails++; $display("FAIL reset_mbe: got %b expected 0", mbe); end
      tests++; if (mwen !== 1'b1)   begin fails++; $display("FAIL reset_mwen: got %b expected 1", mwen); end
      tests++; if (rdata !== '0)    begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      tests++; if (opc !== 1'b0)    begin fails++; $display("FAIL reset_opc: got %b expected 0", opc); end
      tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (err !== 1'b0)    begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
      next_cycle();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] eg;
      logic [AW-1:0] ea;
      do_reset();
      add  = {32'h2000_0004, 32'h2000_0000};
      mgnt = 1'b1;
      for (int k = 0; k < 5; k++) begin
         req    = (k < 4) ? 2'b11 : 2'b00;
         mrv    = (k > 0);
         mrdata = (k > 0) ? 32'hA0 + 32'(k - 1) : '0;
         @(negedge clk);
         if (k < 4) begin
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            ea = (k % 2 == 0) ? 32'h2000_0000 : 32'h2000_0004;
            tests++; if (gnt !== eg) begin fails++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, eg); end
            tests++; if (madd !== ea) begin fails++; $display("FAIL rr_addr[%0d]: got %h expected %h", k, madd, ea); end
         end
         if (k > 0) begin
            eg = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (rvalid !== eg) begin fails++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, rvalid, eg); end
            tests++; if (rdata !== 32'hA0 + 32'(k - 1)) begin fails++; $display("FAIL rr_rdata[%0d]: got %h expected %h", k, rdata, 32'hA0 + 32'(k - 1)); end
         end
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_drained_busy: got %b expected 0", busy); end
      next_cycle();
   endtask

   task automatic test_outstanding_limit();
      do_reset();
      req  = 2'b01;
      mgnt = 1'b1;
      for (int k = 0; k < 5; k++) begin
         mrv = (k == 4);
         @(negedge clk);
         if (k < 2 || k == 4) begin
            tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL lim_gnt[%0d]: got %b expected 01", k, gnt); end
         end else begin
            tests++; if (mreq !== 1'b0) begin fails++; $display("FAIL lim_full_mreq[%0d]: got %b expected 0", k, mreq); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL lim_full_busy[%0d]: got %b expected 1", k, busy); end
         end
         if (k == 4) begin
            tests++; if (rvalid !== 2'b01) begin fails++; $display("FAIL lim_bypass_rvalid: got %b expected 01", rvalid); end
         end
         next_cycle();
      end
      req = 2'b00;
      mrv = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         tests++; if (rvalid !== 2'b01) begin fails++; $display("FAIL lim_drain_rvalid[%0d]: got %b expected 01", k, rvalid); end
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL lim_empty_busy: got %b expected 0", busy); end
      next_cycle();
   endtask

   task automatic test_stall();
      do_reset();
      add  = {32'h3000_0100, 32'h3000_0000};
      req  = 2'b01;
      mgnt = 1'b1;
      next_cycle();
      req  = 2'b00;
      mgnt = 1'b0;
      mrv  = 1'b1;
      next_cycle();
      mrv = 1'b0;
      req = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++; if (madd !== 32'h3000_0100) begin fails++; $display("FAIL stall_addr[%0d]: got %h expected 30000100", k, madd); end
         tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL stall_gnt[%0d]: got %b expected 00", k, gnt); end
         next_cycle();
      end
      mgnt = 1'b1;
      @(negedge clk);
      tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL stall_release_gnt: got %b expected 10", gnt); end
      next_cycle();
      mgnt = 1'b0;
      mrv  = 1'b1;
      @(negedge clk);
      tests++; if (madd !== 32'h3000_0000) begin fails++; $display("FAIL stall_rr_wrap_addr: got %h expected 30000000", madd); end
      tests++; if (rvalid !== 2'b10) begin fails++; $display("FAIL stall_rvalid: got %b expected 10", rvalid); end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_unexpected_response();
      do_reset();
      mrv    = 1'b1;
      mrdata = 32'hDEAD;
      @(negedge clk);
      tests++; if (rvalid !== 2'b00) begin fails++; $display("FAIL unexp_rvalid: got %b expected 00", rvalid); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL unexp_err_early: got %b expected 0", err); end
      next_cycle();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++; if (err !== 1'b1) begin fails++; $display("FAIL unexp_err_sticky[%0d]: got %b expected 1", k, err); end
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL unexp_busy[%0d]: got %b expected 0", k, busy); end
         next_cycle();
      end
      do_reset();
      @(negedge clk);
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL unexp_err_cleared: got %b expected 0", err); end
      next_cycle();
   endtask

   task automatic test_write_error();
      do_reset();
      req   = 2'b10;
      wen   = 2'b01;
      be    = {4'b0011, 4'b1111};
      wdata = {32'h0000_1234, 32'hFFFF_FFFF};
      add   = {32'h4000_0008, 32'h4000_0000};
      mgnt  = 1'b1;
      @(negedge clk);
      tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL wr_gnt: got %b expected 10", gnt); end
      tests++; if (mbe !== 4'b0011) begin fails++; $display("FAIL wr_be: got %b expected 0011", mbe); end
      tests++; if (mwen !== 1'b0) begin fails++; $display("FAIL wr_wen: got %b expected 0", mwen); end
      tests++; if (mwdata !== 32'h1234) begin fails++; $display("FAIL wr_wdata: got %h expected 00001234", mwdata); end
      next_cycle();
      idle_inputs();
      mrv   = 1'b1;
      mropc = 1'b1;
      @(negedge clk);
      tests++; if (rvalid !== 2'b10) begin fails++; $display("FAIL wr_rvalid: got %b expected 10", rvalid); end
      tests++; if (opc !== 1'b1) begin fails++; $display("FAIL wr_opc: got %b expected 1", opc); end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_random_traffic();
      int           rr;
      int           q[$];
      bit           err_m;
      int           s;
      bit           found;
      bit           epop;
      bit           emreq;
      logic [N-1:0] eg;
      logic [N-1:0] erv;
      logic [AW-1:0] ea;
      logic [BW-1:0] eb;
      logic         ew;
      do_reset();
      rr    = 0;
      err_m = 1'b0;
      q     = {};
      for (int c = 0; c < 400; c++) begin
         req    = N'($urandom_range(0, (1 << N) - 1));
         mgnt   = ($urandom_range(0, 3) != 0);
         add    = {$urandom, $urandom};
         wdata  = {$urandom, $urandom};
         be     = N*BW'($urandom);
         wen    = N'($urandom);
         mrdata = $urandom;
         mropc  = $urandom_range(0, 1) == 1;
         mrv    = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 31) == 0);
         @(negedge clk);
         epop  = mrv && (q.size() > 0);
         emreq = (|req) && ((q.size() < MO) || epop);
         s     = 0;
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!found && req[(rr + k) % N]) begin
               s     = (rr + k) % N;
               found = 1'b1;
            end
         end
         eg = '0;
         if (emreq && mgnt) eg[s] = 1'b1;
         erv = '0;
         if (epop) erv[q[0]] = 1'b1;
         ea = emreq ? add[s*AW +: AW] : '0;
         eb = emreq ? be[s*BW +: BW] : '0;
         ew = emreq ? wen[s] : 1'b1;
         tests++; if (mreq !== emreq) begin fails++; $display("FAIL rnd_mreq[%0d]: got %b expected %b", c, mreq, emreq); end
         tests++; if (gnt !== eg) begin fails++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt, eg); end
         tests++; if (rvalid !== erv) begin fails++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c, rvalid, erv); end
         tests++; if (madd !== ea) begin fails++; $display("FAIL rnd_addr[%0d]: got %h expected %h", c, madd, ea); end
         tests++; if (mbe !== eb || mwen !== ew) begin fails++; $display("FAIL rnd_be_wen[%0d]: got %b/%b expected %b/%b", c, mbe, mwen, eb, ew); end
         tests++; if (rdata !== (mrv ? mrdata : 32'h0)) begin fails++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, rdata, mrv ? mrdata : 32'h0); end
         tests++; if (busy !== (q.size() != 0)) begin fails++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, busy, q.size() != 0); end
         tests++; if (err !== err_m) begin fails++; $display("FAIL rnd_err[%0d]: got %b expected %b", c, err, err_m); end
         if (epop) void'(q.pop_front());
         else if (mrv) err_m = 1'b1;
         if (emreq && mgnt) begin
            q.push_back(s);
            rr = (s + 1) % N;
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      next_cycle();
      test_reset();
      test_round_robin();
      test_outstanding_limit();
      test_stall();
      test_unexpected_response();
      test_write_error();
      test_random_traffic();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
